// File: rtl/if_fetch_controller.sv
// Input-feature fetch controller: walks a rows x cols x chans tile, issuing one
// granted read per feature word and clearing the IF accumulator at each channel start.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for start, configuration latched on acceptance
// S_CLEAR | one-cycle accumulator clear ahead of each channel, no read
// S_FETCH | read request held until granted, counters advance per beat
// S_DONE  | one-cycle completion pulse, then back to idle
module if_fetch_controller #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int CH_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_if,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [CH_W-1:0]   cfg_chans,
    input  logic              if_gnt,
    output logic              if_ready,
    output logic              if_read,
    output logic [ADDR_W-1:0] if_addr,
    output logic              clr_if,
    output logic              ch_last,
    output logic              if_done
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FETCH, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DIM_W-1:0]  rows_q, cols_q, col_q, row_q;
    logic [CH_W-1:0]   chans_q, ch_q;

    logic cfg_zero, beat, last_col, last_row, last_ch, run_abort, start_acc;

    assign cfg_zero  = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_chans == '0);
    assign beat      = (state == S_FETCH) && if_gnt;
    assign last_col  = (col_q == cols_q - DIM_W'(1));
    assign last_row  = (row_q == rows_q - DIM_W'(1));
    assign last_ch   = (ch_q == chans_q - CH_W'(1));
    assign run_abort = abort && (state != S_IDLE);
    assign start_acc = (state == S_IDLE) && start_if;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (run_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_if) state_nxt = cfg_zero ? S_DONE : S_CLEAR;
                S_CLEAR: state_nxt = S_FETCH;
                S_FETCH: if (beat && last_col && last_row)
                             state_nxt = last_ch ? S_DONE : S_CLEAR;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only, so if_gnt never reaches if_read.
    always_comb begin
        if_ready = 1'b0;
        if_read  = 1'b0;
        clr_if   = 1'b0;
        if_done  = 1'b0;
        ch_last  = 1'b0;
        case (state)
            S_IDLE:  if_ready = 1'b1;
            S_CLEAR: begin
                clr_if  = 1'b1;
                ch_last = last_ch;
            end
            S_FETCH: begin
                if_read = 1'b1;
                ch_last = last_ch;
            end
            S_DONE:  if_done = 1'b1;
            default: if_ready = 1'b0;
        endcase
    end

    assign if_addr = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            chans_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
        end else if (run_abort) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (start_acc) begin
            addr_q  <= cfg_base;
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            chans_q <= cfg_chans;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
        end else if (beat) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (last_col) begin
                col_q <= '0;
                if (last_row) begin
                    row_q <= '0;
                    ch_q  <= last_ch ? '0 : ch_q + CH_W'(1);
                end else begin
                    row_q <= row_q + DIM_W'(1);
                end
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller: per-cycle traces of each run are
// compared against hand-derived cycle tables.
module tb_if_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_if = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [7:0]  cfg_rows = '0;
    logic [7:0]  cfg_cols = '0;
    logic [5:0]  cfg_chans = '0;
    logic        if_gnt = 1'b0;
    logic        if_ready, if_read, clr_if, ch_last, if_done;
    logic [15:0] if_addr;

    int checks = 0;
    int errors = 0;

    logic        r_read[$], r_clr[$], r_done[$], r_last[$], r_ready[$], r_gnt[$];
    logic [15:0] r_addr[$];

    if_fetch_controller #(.ADDR_W(16), .DIM_W(8), .CH_W(6)) dut (
        .clk(clk), .rst(rst), .start_if(start_if), .abort(abort),
        .cfg_base(cfg_base), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_chans(cfg_chans), .if_gnt(if_gnt), .if_ready(if_ready),
        .if_read(if_read), .if_addr(if_addr), .clr_if(clr_if),
        .ch_last(ch_last), .if_done(if_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] b, input logic [7:0] r,
                            input logic [7:0] c, input logic [5:0] ch);
        cfg_base  = b;
        cfg_rows  = r;
        cfg_cols  = c;
        cfg_chans = ch;
        start_if  = 1'b1;
        step();
        start_if  = 1'b0;
    endtask

    // Records one trace entry per cycle until if_done shows; grant pattern bit k
    // applies to the k-th cycle with if_read high, grants are 1 beyond the pattern.
    task automatic run(input int max_cyc, input logic [15:0] gpat, input int glen,
                       output bit got_done);
        int k;
        k = 0;
        got_done = 1'b0;
        r_read.delete(); r_clr.delete(); r_done.delete(); r_last.delete();
        r_ready.delete(); r_gnt.delete(); r_addr.delete();
        for (int i = 0; i < max_cyc; i++) begin
            if (if_read) begin
                if_gnt = (k < glen) ? gpat[k] : 1'b1;
                k++;
            end else begin
                if_gnt = 1'b1;
            end
            r_read.push_back(if_read);
            r_clr.push_back(clr_if);
            r_done.push_back(if_done);
            r_last.push_back(ch_last);
            r_ready.push_back(if_ready);
            r_gnt.push_back(if_gnt);
            r_addr.push_back(if_addr);
            if (if_done) begin
                got_done = 1'b1;
                break;
            end
            step();
        end
        if_gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({if_ready, if_read, clr_if, if_done, ch_last} !== 5'b10000 || if_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values got rdy=%b rd=%b clr=%b done=%b last=%b addr=%h exp 1 0 0 0 0 0000",
                     if_ready, if_read, clr_if, if_done, ch_last, if_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (if_ready !== 1'b1 || if_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b rd=%b exp 1 0", if_ready, if_read);
        end
    endtask

    task automatic test_basic();
        bit gd;
        logic [15:0] ea;
        logic [3:0] exp_v, got_v;
        do_start(16'h0100, 8'd2, 8'd3, 6'd1);
        run(40, 16'hFFFF, 0, gd);
        checks++;
        if (!gd || r_read.size() != 8) begin
            errors++;
            $display("FAIL basic_len got done=%0d cycles=%0d exp 1 8", gd, r_read.size());
        end
        for (int i = 0; i < r_read.size(); i++) begin
            exp_v = {(i >= 1 && i <= 6), (i == 0), (i == 7), (i <= 6)};
            got_v = {r_read[i], r_clr[i], r_done[i], r_last[i]};
            ea = 16'(16'h0100 + i - 1);
            checks++;
            if (got_v !== exp_v || (exp_v[3] && r_addr[i] !== ea)) begin
                errors++;
                $display("FAIL basic_cyc%0d got rd/clr/done/last=%b addr=%h exp %b %h",
                         i, got_v, r_addr[i], exp_v, ea);
            end
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready got rdy=%b done=%b exp 1 0", if_ready, if_done);
        end
    endtask

    task automatic test_multi_channel();
        bit gd;
        logic [15:0] ea;
        logic [3:0] exp_v, got_v;
        do_start(16'h0040, 8'd1, 8'd2, 6'd3);
        run(40, 16'hFFFF, 0, gd);
        checks++;
        if (!gd || r_read.size() != 10) begin
            errors++;
            $display("FAIL multi_len got done=%0d cycles=%0d exp 1 10", gd, r_read.size());
        end
        for (int i = 0; i < r_read.size(); i++) begin
            exp_v = {(i % 3 != 0 && i < 9), (i % 3 == 0 && i < 9), (i == 9), (i >= 6 && i < 9)};
            got_v = {r_read[i], r_clr[i], r_done[i], r_last[i]};
            ea = 16'(16'h0040 + (i / 3) * 2 + (i % 3) - 1);
            checks++;
            if (got_v !== exp_v || (exp_v[3] && r_addr[i] !== ea)) begin
                errors++;
                $display("FAIL multi_cyc%0d got rd/clr/done/last=%b addr=%h exp %b %h",
                         i, got_v, r_addr[i], exp_v, ea);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        bit gd;
        int beats;
        logic [15:0] exp_a [7] = '{16'h0200, 16'h0201, 16'h0201, 16'h0201,
                                   16'h0202, 16'h0203, 16'h0203};
        do_start(16'h0200, 8'd1, 8'd4, 6'd1);
        run(40, 16'b1011001, 7, gd);
        beats = 0;
        for (int i = 0; i < r_read.size(); i++)
            if (r_read[i] && r_gnt[i]) beats++;
        checks++;
        if (!gd || r_read.size() != 9 || beats != 4) begin
            errors++;
            $display("FAIL bp_len got done=%0d cycles=%0d beats=%0d exp 1 9 4",
                     gd, r_read.size(), beats);
        end
        for (int i = 1; i < r_read.size() && i <= 7; i++) begin
            checks++;
            if (r_read[i] !== 1'b1 || r_addr[i] !== exp_a[i-1]) begin
                errors++;
                $display("FAIL bp_cyc%0d got rd=%b addr=%h exp 1 %h", i, r_read[i], r_addr[i], exp_a[i-1]);
            end
        end
        step();
    endtask

    task automatic test_wrap();
        bit gd;
        logic [15:0] ea;
        do_start(16'hFFFE, 8'd1, 8'd4, 6'd1);
        run(40, 16'hFFFF, 0, gd);
        checks++;
        if (!gd || r_read.size() != 6) begin
            errors++;
            $display("FAIL wrap_len got done=%0d cycles=%0d exp 1 6", gd, r_read.size());
        end
        for (int i = 1; i < r_read.size() && i <= 4; i++) begin
            ea = 16'(16'hFFFE + i - 1);
            checks++;
            if (r_read[i] !== 1'b1 || r_addr[i] !== ea) begin
                errors++;
                $display("FAIL wrap_cyc%0d got rd=%b addr=%h exp 1 %h", i, r_read[i], r_addr[i], ea);
            end
        end
        step();
    endtask

    task automatic test_zero();
        bit gd;
        do_start(16'h0700, 8'd3, 8'd0, 6'd2);
        run(10, 16'hFFFF, 0, gd);
        checks++;
        if (!gd || r_read.size() != 1 || r_read[0] !== 1'b0 || r_clr[0] !== 1'b0 || r_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%0d cycles=%0d rd=%b clr=%b rdy=%b exp 1 1 0 0 0",
                     gd, r_read.size(), r_read[0], r_clr[0], r_ready[0]);
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready got rdy=%b done=%b exp 1 0", if_ready, if_done);
        end
    endtask

    task automatic test_abort();
        bit gd;
        bit seen_done;
        do_start(16'h0300, 8'd2, 8'd3, 6'd1);
        if_gnt = 1'b1;
        step();
        step();
        step();
        checks++;
        if (if_read !== 1'b1 || if_addr !== 16'h0302) begin
            errors++;
            $display("FAIL abort_beat3 got rd=%b addr=%h exp 1 0302", if_read, if_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        if_gnt = 1'b0;
        checks++;
        if (if_read !== 1'b0 || if_ready !== 1'b1 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got rd=%b rdy=%b done=%b exp 0 1 0", if_read, if_ready, if_done);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (if_done || if_read) seen_done = 1'b1;
            step();
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL abort_quiet got activity=1 exp 0");
        end
        do_start(16'h0400, 8'd1, 8'd2, 6'd1);
        run(40, 16'hFFFF, 0, gd);
        checks++;
        if (!gd || r_read.size() != 4 || r_addr[1] !== 16'h0400 || r_addr[2] !== 16'h0401 || r_clr[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun got done=%0d cycles=%0d a1=%h a2=%h clr0=%b exp 1 4 0400 0401 1",
                     gd, r_read.size(), r_addr[1], r_addr[2], r_clr[0]);
        end
        step();
    endtask

    task automatic test_start_ignored();
        bit gd;
        int beats;
        do_start(16'h0500, 8'd2, 8'd3, 6'd1);
        cfg_base = 16'h0900;
        cfg_cols = 8'd1;
        start_if = 1'b1;
        if_gnt   = 1'b1;
        step();
        start_if = 1'b0;
        run(40, 16'hFFFF, 0, gd);
        beats = 0;
        for (int i = 0; i < r_read.size(); i++)
            if (r_read[i] && r_gnt[i]) beats++;
        checks++;
        if (!gd || r_read.size() != 7 || beats != 6) begin
            errors++;
            $display("FAIL ignore_len got done=%0d cycles=%0d beats=%0d exp 1 7 6",
                     gd, r_read.size(), beats);
        end
        for (int i = 0; i < r_read.size() && i < 6; i++) begin
            checks++;
            if (r_addr[i] !== 16'(16'h0500 + i)) begin
                errors++;
                $display("FAIL ignore_cyc%0d got addr=%h exp %h", i, r_addr[i], 16'(16'h0500 + i));
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_start(16'h0600, 8'd2, 8'd3, 6'd1);
        if_gnt = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({if_ready, if_read, clr_if, if_done, ch_last} !== 5'b10000 || if_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b rd=%b clr=%b done=%b last=%b addr=%h exp 1 0 0 0 0 0000",
                     if_ready, if_read, clr_if, if_done, ch_last, if_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (if_ready !== 1'b1 || if_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got rdy=%b rd=%b exp 1 0", if_ready, if_read);
        end
        if_gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_channel();
        test_backpressure();
        test_wrap();
        test_zero();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_controller.md
Name: if_fetch_controller

Overview:
Parametrised input-feature fetch controller for the CNN accelerator datapath. It accepts a start request with a tile configuration of base address, rows, columns and channels. It then issues one read request per feature word to the IF buffer/memory under a grant handshake, and pulses a clear to the IF accumulator at the start of every channel. It counts its own completion and replaces the external done input with an internal done pulse. It also adds abort support.

Parameters:
ADDR_W, 16, width of the IF read address
DIM_W, 8, width of the row and column count fields (max 2^DIM_W-1)
CH_W, 6, width of the channel count field

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start_if  in  1  start request; accepted only while if_ready=1
abort  in  1  synchronous abort; returns to IDLE next cycle
cfg_base  in  ADDR_W  first word address
cfg_rows  in  DIM_W  rows per channel
cfg_cols  in  DIM_W  columns per row
cfg_chans  in  CH_W  channel count
if_gnt  in  1  memory accepted current request (beat completes when if_read & if_gnt)
if_ready  out  1  idle, can accept start
if_read  out  1  read request valid
if_addr  out  ADDR_W  read address, valid when if_read=1
clr_if  out  1  one-cycle clear pulse to IF accumulator
ch_last  out  1  current beat belongs to last channel
if_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE, if_ready=1, if_read=0, clr_if=0, if_done=0, ch_last=0, if_addr=0, counters=0. All outputs are fully defined in every state; no X is driven.
- States:
  - IDLE: if_ready=1. start_if=1 latches cfg_* and loads if_addr=cfg_base. If any of rows/cols/chans is 0, go to DONE. Otherwise go to CLEAR.
  - CLEAR: clr_if=1 and if_read=0 for exactly 1 cycle, then go to FETCH.
  - FETCH: if_read=1 and if_addr held stable until if_gnt. On each granted beat: if_addr+=1 (mod 2^ADDR_W, wraps silently); col++; at col==cols-1 col=0, row++; at row==rows-1 row=0, ch++.
  - End of channel: a granted beat ending a non-last channel goes to CLEAR, giving a 1-cycle bubble with if_read=0. A granted final beat (last col, row, ch) goes to DONE.
  - DONE: if_done=1 for 1 cycle, if_ready=0, then go to IDLE.
- Handshake: if_read is never dropped without a grant while in FETCH. No combinational path from if_gnt to if_read. if_gnt is ignored when if_read=0.
- Latency: start accepted at edge N gives clr_if during N+1 and first if_read during N+2. Total beats = rows*cols*chans. With if_gnt tied high, done is at start + 2 + beats + (chans-1) cycles.
- Configuration is sampled only at start acceptance. cfg_* changes during a run are ignored.
- start_if while if_ready=0 is ignored; it is not queued.
- abort=1 in any non-IDLE state goes to IDLE next edge with if_read=0, no if_done pulse and counters cleared. abort in IDLE has no effect. abort has priority over a simultaneous final grant, so no done is issued.
- ch_last=1 while the channel counter equals chans-1 (during its CLEAR and FETCH).
- Async reset mid-run returns immediately to reset values.

Test Plan:
- Basic: base=0x0100, rows=2, cols=3, chans=1, if_gnt=1 -> clr_if 1 cycle, 6 reads with addresses 0x0100..0x0105, if_done 1 cycle, if_ready back to 1; ch_last=1 throughout.
- Multi-channel: rows=1, cols=2, chans=3 -> 3 clr_if pulses, each followed by 2 reads; addresses contiguous 0..5 from base; 1-cycle gap at channel boundaries; ch_last only during the third channel.
- Backpressure: rows=1, cols=4, chans=1, if_gnt pattern 1,0,0,1,1,0,1 -> if_addr holds during each 0; exactly 4 beats; done after the 4th grant.
- Wrap and zero: base=0xFFFE, rows=1, cols=4 -> addresses FFFE, FFFF, 0000, 0001. Separately, cols=0 -> no if_read, no clr_if, if_done 1 cycle after start.
- Abort: abort asserted on the 3rd beat of a 6-beat run with a simultaneous grant -> if_read=0 next cycle, no if_done, if_ready=1. A new start then runs correctly from the new cfg_base.
- Reset mid-FETCH: drive rst=0 asynchronously -> outputs take reset values without waiting for a clock edge. start_if during a run is ignored, with no extra beats.
